// File: rtl/norm_pkg.sv
// norm_pkg: shared defaults and beat type for the norm_shift normalizer
package norm_pkg;
  localparam int WI_SZ_DEF = 32;
  localparam int WO_SZ_DEF = $clog2(WI_SZ_DEF) + 1;
  localparam int EXP_SZ_DEF = 8;
  typedef struct packed {
    logic [WI_SZ_DEF-1:0] data;
    logic [WO_SZ_DEF-1:0] lzc;
    logic [EXP_SZ_DEF-1:0] exp;
  } norm_beat_t;
endpackage

// File: rtl/norm_pipe_reg.sv
// norm_pipe_reg: single valid/ready register slice, async active-high reset
module norm_pipe_reg
  import norm_pkg::*;
#(
  parameter type T = norm_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  logic valid_q;
  T data_q;
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o = data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
endmodule

// File: rtl/norm_shift.sv
// norm_shift: two-stage normalizer (S1 capture, S2 shift + exponent adjust).
// Define NORM_UFLOW_CLAMP_EN to clamp the shift at the exponent (denormal output on underflow).
module norm_shift
  import norm_pkg::*;
#(
  parameter int WI_SZ = WI_SZ_DEF,
  parameter int WO_SZ = $clog2(WI_SZ) + 1,
  parameter int EXP_SZ = EXP_SZ_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WI_SZ-1:0]  in_data,
  input  logic [WO_SZ-1:0]  in_lzc,
  input  logic [EXP_SZ-1:0] in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WI_SZ-1:0]  out_data,
  output logic [EXP_SZ-1:0] out_exp,
  output logic              out_zero,
  output logic              out_uflow
);
  localparam int SH_W = EXP_SZ > WO_SZ ? EXP_SZ : WO_SZ;
  typedef struct packed {
    logic [WI_SZ-1:0] data;
    logic [WO_SZ-1:0] lzc;
    logic [EXP_SZ-1:0] exp;
  } beat_t;
  typedef struct packed {
    logic [WI_SZ-1:0] data;
    logic [EXP_SZ-1:0] exp;
    logic zero;
    logic uflow;
  } res_t;
  beat_t in_beat, s1_q;
  res_t res_d, s2_q;
  logic s1_ready, s1_valid, s2_ready;
  logic [WO_SZ-1:0] lzc_sat;
  logic [EXP_SZ:0] diff;
  logic [SH_W-1:0] shamt;
  logic zero;
  assign in_beat = '{data: in_data, lzc: in_lzc, exp: in_exp};
  assign in_ready = !rst && s1_ready;
  norm_pipe_reg #(.T(beat_t)) u_s1 (
    .clk(clk), .rst(rst),
    .valid_i(in_valid), .ready_o(s1_ready), .data_i(in_beat),
    .valid_o(s1_valid), .ready_i(s2_ready), .data_o(s1_q)
  );
  // borrow out of the EXP_SZ+1 subtract is the underflow flag
  always_comb begin
    lzc_sat = s1_q.lzc > WO_SZ'(WI_SZ) ? WO_SZ'(WI_SZ) : s1_q.lzc;
    zero = lzc_sat == WO_SZ'(WI_SZ);
    diff = {1'b0, s1_q.exp} - (EXP_SZ+1)'(lzc_sat);
`ifdef NORM_UFLOW_CLAMP_EN
    shamt = diff[EXP_SZ] ? SH_W'(s1_q.exp) : SH_W'(lzc_sat);
    res_d.exp = diff[EXP_SZ] ? '0 : diff[EXP_SZ-1:0];
`else
    shamt = SH_W'(lzc_sat);
    res_d.exp = diff[EXP_SZ-1:0];
`endif
    res_d.data = zero ? '0 : s1_q.data << shamt;
    res_d.exp = zero ? '0 : res_d.exp;
    res_d.zero = zero;
    res_d.uflow = !zero && diff[EXP_SZ];
  end
  norm_pipe_reg #(.T(res_t)) u_s2 (
    .clk(clk), .rst(rst),
    .valid_i(s1_valid), .ready_o(s2_ready), .data_i(res_d),
    .valid_o(out_valid), .ready_i(out_ready), .data_o(s2_q)
  );
  assign out_data = s2_q.data;
  assign out_exp = s2_q.exp;
  assign out_zero = s2_q.zero;
  assign out_uflow = s2_q.uflow;
endmodule

// File: tb/tb_norm_shift.sv
// tb_norm_shift: directed and randomized checks of norm_shift against a behavioural model
module tb_norm_shift;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_zero, out_uflow;
  logic [31:0] in_data = '0, out_data;
  logic [5:0] in_lzc = '0;
  logic [7:0] in_exp = '0, out_exp;
  int checks = 0, errors = 0;
  logic acc;
  logic [41:0] exp_q[$];

  always #5 clk = ~clk;

  norm_shift dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lzc(in_lzc), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_exp(out_exp),
    .out_zero(out_zero), .out_uflow(out_uflow)
  );

  function automatic logic [41:0] model(logic [31:0] d, int lzc, int e);
    int l, ex;
    logic [31:0] r;
    logic u;
    l = lzc > 32 ? 32 : lzc;
    if (l == 32) return {32'h0, 8'h0, 1'b1, 1'b0};
    u = l > e;
`ifdef NORM_UFLOW_CLAMP_EN
    r = u ? d << e : d << l;
    ex = u ? 0 : e - l;
`else
    r = d << l;
    ex = (e - l) & 255;
`endif
    return {r, 8'(ex), 1'b0, u};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, req);
    end
  endtask

  // one clock: sample handshakes at negedge, return 1 unit after posedge
  task automatic step();
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
      else if (out_ready) chk("result", 64'({out_data, out_exp, out_zero, out_uflow}), 64'(exp_q.pop_front()));
      else chk("stall_hold", 64'({out_data, out_exp, out_zero, out_uflow}), 64'(exp_q[0]));
    end
    if (acc) exp_q.push_back(model(in_data, int'(in_lzc), int'(in_exp)));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(string tag, logic [31:0] d, int l, int e, logic [41:0] want);
    out_ready = 1; in_valid = 1; in_data = d; in_lzc = 6'(l); in_exp = 8'(e);
    step();
    in_valid = 0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    chk(tag, 64'({out_data, out_exp, out_zero, out_uflow}), 64'(want));
    step();
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_beat();
    logic [31:0] d;
    int z;
    d = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 7) == 0) d = '0;
    z = 32;
    for (int b = 31; b >= 0; b--) if (d[b] && z == 32) z = 31 - b;
    in_data = d;
    in_lzc = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : 6'(z);
    in_exp = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    logic [31:0] bd[4];
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_exp", 64'(out_exp), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_out_uflow", 64'(out_uflow), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    directed("normal", 32'h0000_1234, 19, 100, {32'h91A0_0000, 8'd81, 2'b00});
    directed("zero", 32'h0, 32, 50, {32'h0, 8'd0, 2'b10});
    directed("saturate", 32'h0000_0005, 40, 77, {32'h0, 8'd0, 2'b10});
    directed("lzc0_exp0", 32'h8000_0001, 0, 0, {32'h8000_0001, 8'd0, 2'b00});
    directed("lzc_eq_exp", 32'h0000_00FF, 24, 24, {32'hFF00_0000, 8'd0, 2'b00});
`ifdef NORM_UFLOW_CLAMP_EN
    directed("uflow", 32'h0000_0001, 31, 10, {32'h0000_0400, 8'd0, 2'b01});
`else
    directed("uflow", 32'h0000_0001, 31, 10, {32'h8000_0000, 8'd235, 2'b01});
`endif

    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() > 0); c++) begin
      in_valid = idx < 4;
      if (idx < 4) begin
        in_data = bd[idx]; in_lzc = 6'(idx * 3); in_exp = 8'(100 + idx);
      end
      out_ready = c >= 3;
      if (c == 2) chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      step();
      if (acc) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd4);
    chk("bp_all_out", 64'(exp_q.size()), 64'd0);

    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; rand_beat();
      step();
    end
    in_valid = 0;
    chk("mid_full", 64'(out_valid), 64'd1);
    rst = 1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 0;
    #1 chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end

    for (int c = 0; c < 600; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      rand_beat();
      out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/norm_shift.md
NORM_SHIFT -- requirements
Module: norm_shift

Interface
REQ-001 Parameter WI_SZ, default 32: data width; SHALL be a power of two, 4 or greater.
REQ-002 Parameter WO_SZ, default $clog2(WI_SZ)+1: width of the leading-zero count.
REQ-003 Parameter EXP_SZ, default 8: width of the unsigned exponent.
REQ-004 Ports SHALL be, in this order:
- clk, input, 1: the single clock.
- rst, input, 1: reset, asynchronous and active-high.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: block can accept a beat.
- in_data, input, WI_SZ: raw value.
- in_lzc, input, WO_SZ: leading-zero count of in_data, from the upstream counter.
- in_exp, input, EXP_SZ: exponent that goes with in_data.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream can accept the result.
- out_data, output, WI_SZ: normalized value.
- out_exp, output, EXP_SZ: adjusted exponent.
- out_zero, output, 1: the input value was zero.
- out_uflow, output, 1: in_lzc was greater than in_exp.

Function
REQ-005 Transfer rule: a beat moves on an edge of clk when valid && ready; valid SHALL NOT depend combinationally on ready.
REQ-006 Pipeline: two register stages, S1 (capture) and S2 (shift and exponent math).
- Latency: 2 cycles from acceptance to out_valid, with no stall.
- Throughput: 1 beat per cycle.
REQ-007 Stage advance: a stage advances when the next stage is empty or is itself advancing; in_ready = !S1_valid || S1 advancing. A combinational path from out_ready to in_ready is allowed.
REQ-008 Stall: while out_valid && !out_ready, all out_* SHALL hold stable. No beat is dropped, duplicated or reordered.
REQ-009 Saturation: an in_lzc greater than WI_SZ SHALL be treated as WI_SZ.
REQ-010 Zero: when in_lzc == WI_SZ, the result SHALL be out_data=0, out_exp=0, out_zero=1, out_uflow=0.
REQ-011 Non-zero: shamt = in_lzc (see REQ-016); out_data = in_data << shamt; out_exp = in_exp - shamt; out_zero=0.
REQ-012 Underflow flag: out_uflow = (in_lzc > in_exp) for a non-zero input.
REQ-013 Widths: the shift uses logical zero-fill; the exponent subtract is computed at EXP_SZ+1 bits, and the borrow bit is the underflow flag.

Reset
REQ-014 While rst is high: in_ready=0, out_valid=0, out_data=0, out_exp=0, out_zero=0, out_uflow=0, and both stage valid bits are 0.
REQ-015 Reset asserted mid-stream discards all in-flight beats. In the first cycle after deassertion, in_ready=1.

Configuration
REQ-016 Macro NORM_UFLOW_CLAMP_EN, behaviour when defined:
- shamt = min(in_lzc, in_exp).
- On underflow: out_exp=0, out_uflow=1, and out_data is partially normalized (denormal).
REQ-017 Behaviour when NORM_UFLOW_CLAMP_EN is undefined:
- shamt = in_lzc.
- On underflow: out_exp wraps modulo 2^EXP_SZ and out_uflow=1.
- Port list is identical in both builds.

Structure
REQ-018 Package norm_pkg SHALL hold:
- WI_SZ, WO_SZ and EXP_SZ defaults.
- A struct norm_beat_t with fields data, lzc, exp.
REQ-019 One sub-module, norm_pipe_reg: a valid/ready register slice carrying norm_beat_t, with async active-high reset. It is instantiated for S1; S2 also reuses it, or S2 is an inline register.
REQ-020 There is no internal leading-zero counter; in_lzc is trusted as given, subject only to REQ-009.

Verification
REQ-021 Normal: in_data=0x0000_1234, in_lzc=19, in_exp=100, out_ready=1 -> 2 cycles later out_data=0x91A0_0000, out_exp=81, out_zero=0, out_uflow=0.
REQ-022 Zero: in_data=0, in_lzc=32, in_exp=50 -> out_data=0, out_exp=0, out_zero=1, out_uflow=0.
REQ-023 Underflow: in_data=0x0000_0001, in_lzc=31, in_exp=10.
- Clamp build: out_data=0x0000_0400, out_exp=0, out_uflow=1.
- Non-clamp build: out_data=0x8000_0000, out_exp=235, out_uflow=1.
REQ-024 Back-pressure: 4 back-to-back beats with out_ready held low for 3 cycles -> in_ready drops once S1 and S2 are full, out_* hold stable, and all 4 results emerge in order once out_ready=1.
REQ-025 Saturation: in_lzc=40 with WI_SZ=32 -> handled as zero: out_zero=1, out_data=0.
REQ-026 Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 immediately and stays 0 afterwards; no stale beat appears; in_ready=1 on the first cycle after release.
